arbitro_memoria: RTL and testbench

//  Shares one single-port word memory between the processor's instruction-fetch port and its

---
 rtl/arbitro_memoria_if.sv | 48 ++++
 rtl/arbitro_memoria.sv | 149 ++++++++++++++
 tb/tb_arbitro_memoria.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// Interface between the arbiter, the datapath ports and the unified memory.
// slave = arbiter side, master = datapath/memory side.
interface arbitro_memoria_if #(
  parameter int LARGURA_END = 10
);
  logic                   req_inst;
  logic [31:0]            endereco_inst;
  logic [31:0]            instrucao_saida;
  logic                   inst_pronta;
  logic                   req_dados;
  logic                   escrita_dados;
  logic [31:0]            endereco_dados;
  logic [31:0]            dado_escrita;
  logic [31:0]            dado_saida;
  logic                   dados_pronto;
  logic                   mem_req;
  logic                   mem_escrita;
  logic [LARGURA_END-1:0] mem_endereco;
  logic [31:0]            mem_dado_escrita;
  logic [31:0]            mem_dado_leitura;
  logic                   mem_pronto;
  logic                   parar_pc;
  logic                   erro_timeout;

  modport slave (
    input  req_inst, endereco_inst,
    output instrucao_saida, inst_pronta,
    input  req_dados, escrita_dados,
    input  endereco_dados, dado_escrita,
    output dado_saida, dados_pronto,
    output mem_req, mem_escrita,
    output mem_endereco, mem_dado_escrita,
    input  mem_dado_leitura, mem_pronto,
    output parar_pc, erro_timeout
  );

  modport master (
    output req_inst, endereco_inst,
    input  instrucao_saida, inst_pronta,
    output req_dados, escrita_dados,
    output endereco_dados, dado_escrita,
    input  dado_saida, dados_pronto,
    input  mem_req, mem_escrita,
    input  mem_endereco, mem_dado_escrita,
    output mem_dado_leitura, mem_pronto,
    input  parar_pc, erro_timeout
  );
endinterface

// File: rtl/arbitro_memoria.sv
// Shares one single-port word memory between the fetch and load/store
// ports, alternating grants on contention and aborting hung accesses.
module arbitro_memoria #(
  parameter int LARGURA_END = 10,
  parameter int TIMEOUT     = 16
) (
  input logic              clock,
  input logic              reset,
  arbitro_memoria_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    OCIOSO,
    ACESSO,
    RESPOSTA
  } estado_t;

  typedef enum logic {
    INST  = 1'b0,
    DADOS = 1'b1
  } porta_t;

  estado_t                estado_q;
  porta_t                 dono_q;
  porta_t                 ult_q;
  porta_t                 grant_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [LARGURA_END-1:0] end_d;
  logic                   mem_req_q;
  logic                   mem_esc_q;
  logic [LARGURA_END-1:0] mem_end_q;
  logic [31:0]            mem_wd_q;
  logic [31:0]            instr_q;
  logic [31:0]            dado_q;
  logic                   ipronta_q;
  logic                   dpronto_q;
  logic                   erro_q;
  logic                   unused;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_d = INST;
    if (bus.req_dados &&
        (!bus.req_inst || ult_q == INST))
      grant_d = DADOS;
  end

  assign end_d = (grant_d == DADOS)
    ? bus.endereco_dados[LARGURA_END+1:2]
    : bus.endereco_inst[LARGURA_END+1:2];

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      dono_q    <= INST;
      ult_q     <= INST;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_esc_q <= 1'b0;
      mem_end_q <= '0;
      mem_wd_q  <= '0;
      instr_q   <= '0;
      dado_q    <= '0;
      ipronta_q <= 1'b0;
      dpronto_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      ipronta_q <= 1'b0;
      dpronto_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (bus.req_inst || bus.req_dados) begin
            dono_q    <= grant_d;
            mem_end_q <= end_d;
            mem_esc_q <= (grant_d == DADOS)
                         && bus.escrita_dados;
            mem_wd_q  <= (grant_d == DADOS)
                         ? bus.dado_escrita : '0;
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            estado_q  <= ACESSO;
          end
        end
        ACESSO: begin
          if (bus.mem_pronto) begin
            if (dono_q == DADOS) begin
              if (!mem_esc_q)
                dado_q <= bus.mem_dado_leitura;
              dpronto_q <= 1'b1;
            end else begin
              instr_q   <= bus.mem_dado_leitura;
              ipronta_q <= 1'b1;
            end
            mem_req_q <= 1'b0;
            mem_esc_q <= 1'b0;
            estado_q  <= RESPOSTA;
          end else if (cnt_d == TO) begin
            // Abort: a fetch turns into a NOP.
            if (dono_q == DADOS) begin
              if (!mem_esc_q)
                dado_q <= '0;
              dpronto_q <= 1'b1;
            end else begin
              instr_q   <= NOP;
              ipronta_q <= 1'b1;
            end
            erro_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_esc_q <= 1'b0;
            cnt_q     <= cnt_d;
            estado_q  <= RESPOSTA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESPOSTA: begin
          ult_q    <= dono_q;
          cnt_q    <= '0;
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign bus.mem_req          = mem_req_q;
  assign bus.mem_escrita      = mem_esc_q;
  assign bus.mem_endereco     = mem_end_q;
  assign bus.mem_dado_escrita = mem_wd_q;
  assign bus.instrucao_saida  = instr_q;
  assign bus.inst_pronta      = ipronta_q;
  assign bus.dado_saida       = dado_q;
  assign bus.dados_pronto     = dpronto_q;
  assign bus.erro_timeout     = erro_q;
  assign bus.parar_pc =
    (bus.req_inst || bus.req_dados)
    && (estado_q != RESPOSTA);

  assign unused = ^{bus.endereco_inst[31:LARGURA_END+2],
                    bus.endereco_inst[1:0],
                    bus.endereco_dados[31:LARGURA_END+2],
                    bus.endereco_dados[1:0]};
endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: memory model on the bus, expected
// completions queued at request time and popped on each pronto pulse.
module tb_arbitro_memoria;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  arbitro_memoria_if #(.LARGURA_END(10)) bus ();

  arbitro_memoria #(
    .LARGURA_END(10),
    .TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          inst;
    logic [31:0] dado;
  } exp_t;

  typedef struct {
    bit          esc;
    logic [9:0]  ender;
    logic [31:0] dado;
  } acc_t;

  exp_t        sb[$];
  acc_t        acc[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [0:1023];
  int          lat = 2;
  bit          preso = 0;
  bit          espurio = 0;
  bit          ativo = 0;
  int          dur = 0;
  int          ult_dur = 0;
  int          c;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory: answers lat cycles after mem_req rises.
  initial begin
    bus.mem_pronto = 1'b0;
    bus.mem_dado_leitura = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_req) begin
        if (!ativo) begin
          ativo = 1;
          dur = 0;
          acc.push_back('{bus.mem_escrita,
                          bus.mem_endereco,
                          bus.mem_dado_escrita});
        end
        bus.mem_pronto = 1'b0;
        bus.mem_dado_leitura = $urandom;
        if (!preso && dur == lat) begin
          bus.mem_pronto = 1'b1;
          bus.mem_dado_leitura = mem[bus.mem_endereco];
          if (bus.mem_escrita)
            mem[bus.mem_endereco] = bus.mem_dado_escrita;
        end
        dur++;
      end else begin
        if (ativo) ult_dur = dur;
        ativo = 0;
        bus.mem_pronto = espurio;
        bus.mem_dado_leitura = $urandom;
      end
    end
  end

  task automatic consome(input bit inst);
    exp_t e;
    check("sb_vazio", 32'(sb.size() == 0), 0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("porta", 32'(inst), 32'(e.inst));
      if (inst)
        check("instrucao", bus.instrucao_saida, e.dado);
      else
        check("dado_saida", bus.dado_saida, e.dado);
    end
  endtask

  task automatic chk_acc(input string tag, input bit esc,
                         input logic [9:0] ender,
                         input logic [31:0] dado,
                         input bit ver_dado);
    acc_t a;
    check({tag, "_vazio"}, 32'(acc.size() == 0), 0);
    if (acc.size() != 0) begin
      a = acc.pop_front();
      check({tag, "_esc"}, 32'(a.esc), 32'(esc));
      check({tag, "_end"}, 32'(a.ender), 32'(ender));
      if (ver_dado)
        check({tag, "_wd"}, a.dado, dado);
    end
  endtask

  task automatic espera(input int n, input bit manter,
                        output int lat1);
    int vistos = 0;
    int ciclos = 0;
    lat1 = -1;
    while (vistos < n && ciclos < 200) begin
      @(negedge clock);
      ciclos++;
      check("parar_pc", 32'(bus.parar_pc),
            32'((bus.req_inst | bus.req_dados)
                & ~(bus.inst_pronta | bus.dados_pronto)));
      check("sobreposto",
            32'(bus.inst_pronta & bus.dados_pronto), 0);
      if (bus.inst_pronta) begin
        consome(1);
        if (!manter) bus.req_inst = 1'b0;
        vistos++;
        if (lat1 < 0) lat1 = ciclos;
      end
      if (bus.dados_pronto) begin
        consome(0);
        if (!manter) bus.req_dados = 1'b0;
        vistos++;
        if (lat1 < 0) lat1 = ciclos;
      end
    end
    check("espera_to", vistos, n);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h0050_0093;
    mem[8] = 32'hCAFE_0001;

    reset = 1'b1;
    bus.req_inst = 1'b0;
    bus.endereco_inst = '0;
    bus.req_dados = 1'b0;
    bus.escrita_dados = 1'b0;
    bus.endereco_dados = '0;
    bus.dado_escrita = '0;
    repeat (3) @(negedge clock);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_esc", 32'(bus.mem_escrita), 0);
    check("rst_mem_end", 32'(bus.mem_endereco), 0);
    check("rst_ipronta", 32'(bus.inst_pronta), 0);
    check("rst_dpronto", 32'(bus.dados_pronto), 0);
    check("rst_erro", 32'(bus.erro_timeout), 0);
    check("rst_parar", 32'(bus.parar_pc), 0);
    check("rst_instr", bus.instrucao_saida, 0);
    check("rst_dado", bus.dado_saida, 0);
    reset = 1'b0;

    // Single fetch, memory answers 2 cycles after mem_req.
    @(negedge clock);
    lat = 2;
    bus.req_inst = 1'b1;
    bus.endereco_inst = 32'h8;
    sb.push_back('{1, 32'h0050_0093});
    #1 check("t1_parar", 32'(bus.parar_pc), 1);
    espera(1, 0, c);
    check("t1_lat", c, 4);
    chk_acc("t1", 0, 10'd2, '0, 0);
    @(negedge clock);
    check("t1_hold", bus.instrucao_saida, 32'h0050_0093);
    check("t1_pulso", 32'(bus.inst_pronta), 0);

    // First tie after reset goes to data.
    espurio = 1;
    lat = 1;
    bus.req_inst = 1'b1;
    bus.endereco_inst = 32'h4;
    bus.req_dados = 1'b1;
    bus.escrita_dados = 1'b0;
    bus.endereco_dados = 32'h20;
    sb.push_back('{0, 32'hCAFE_0001});
    sb.push_back('{1, 32'h1111_1111});
    espera(2, 0, c);
    chk_acc("t2d", 0, 10'd8, '0, 0);
    chk_acc("t2i", 0, 10'd1, '0, 0);

    // Store at minimum latency; dado_saida keeps the last load.
    @(negedge clock);
    lat = 0;
    bus.req_dados = 1'b1;
    bus.escrita_dados = 1'b1;
    bus.endereco_dados = 32'h10;
    bus.dado_escrita = 32'hDEAD_BEEF;
    sb.push_back('{0, 32'hCAFE_0001});
    espera(1, 0, c);
    check("t3_lat", c, 2);
    chk_acc("t3", 1, 10'd4, 32'hDEAD_BEEF, 1);
    check("t3_mem", mem[4], 32'hDEAD_BEEF);
    bus.escrita_dados = 1'b0;

    // Fetch with a hung memory times out into a NOP.
    @(negedge clock);
    espurio = 0;
    preso = 1;
    bus.req_inst = 1'b1;
    bus.endereco_inst = 32'h0;
    sb.push_back('{1, 32'h0000_0013});
    espera(1, 0, c);
    check("t4_lat", c, 17);
    chk_acc("t4", 0, 10'd0, '0, 0);
    @(negedge clock);
    check("t4_dur", ult_dur, 16);
    check("t4_erro", 32'(bus.erro_timeout), 1);
    preso = 0;
    lat = 1;
    bus.req_dados = 1'b1;
    bus.endereco_dados = 32'h10;
    sb.push_back('{0, 32'hDEAD_BEEF});
    espera(1, 0, c);
    chk_acc("t4b", 0, 10'd4, '0, 0);
    check("t4_sticky", 32'(bus.erro_timeout), 1);

    // Reset during ACESSO, request kept and re-arbitrated.
    @(negedge clock);
    preso = 1;
    bus.req_inst = 1'b1;
    bus.endereco_inst = 32'h4;
    repeat (3) @(negedge clock);
    check("t6_ativo", 32'(bus.mem_req), 1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_mem_req", 32'(bus.mem_req), 0);
    check("t6_ipronta", 32'(bus.inst_pronta), 0);
    check("t6_erro", 32'(bus.erro_timeout), 0);
    check("t6_instr", bus.instrucao_saida, 0);
    acc.delete();
    preso = 0;
    lat = 1;
    reset = 1'b0;
    sb.push_back('{1, 32'h1111_1111});
    espera(1, 0, c);
    chk_acc("t6", 0, 10'd1, '0, 0);

    // Both ports held: grants alternate D,I,D,I,D,I.
    @(negedge clock);
    lat = 0;
    bus.req_dados = 1'b1;
    bus.escrita_dados = 1'b0;
    bus.endereco_dados = 32'h20;
    bus.req_inst = 1'b1;
    bus.endereco_inst = 32'h8;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{0, 32'hCAFE_0001});
      sb.push_back('{1, 32'h0050_0093});
    end
    espera(6, 1, c);
    bus.req_dados = 1'b0;
    bus.req_inst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_acc("t5d", 0, 10'd8, '0, 0);
      chk_acc("t5i", 0, 10'd2, '0, 0);
    end
    @(negedge clock);
    check("t5_parar", 32'(bus.parar_pc), 0);
    check("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
